// File: rtl/beam_sum_accumulator.sv
// Beam sum accumulator: sums every NUM_ELEM good samples from the delay
// beamformer into one beam sample and queues the results in a
// first-word-fall-through FIFO with a valid/ready handshake to readout.
module beam_sum_accumulator #(
  parameter int DATA_W     = 12,
  parameter int NUM_ELEM   = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int SUM_W     = DATA_W + $clog2(NUM_ELEM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_good,
  output logic [SUM_W-1:0]  beam_out,
  output logic              beam_valid,
  input  logic              beam_ready,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       beam_count
);

  localparam int CNT_W = $clog2(NUM_ELEM);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(NUM_ELEM - 1);
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   elem_cnt_q, elem_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [SUM_W-1:0]   beam_out_q, beam_out_d;
  logic               beam_valid_q, beam_valid_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        beam_count_q, beam_count_d;
  logic [SUM_W-1:0]   fifo_mem_q [FIFO_DEPTH];

  logic [SUM_W-1:0]   sum_s;
  logic               grp_done_s;
  logic               pop_s;
  logic               full_s;
  logic               push_ok_s;
  logic               drop_s;

  // Running sum including the current sample; also the value pushed when a group completes
  assign sum_s = acc_q + {{(SUM_W-DATA_W){1'b0}}, sample_in};

  // Acquisition state machine and group accumulation
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    elem_cnt_d = elem_cnt_q;
    grp_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACCUM;
          acc_d      = {SUM_W{1'b0}};
          elem_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d    = IDLE;
        end
      end
      ACCUM: begin
        if (!start) begin
          // Abort: the partial group is thrown away, the strobe this cycle ignored
          state_d    = IDLE;
          acc_d      = {SUM_W{1'b0}};
          elem_cnt_d = {CNT_W{1'b0}};
        end else if (sample_good) begin
          if (elem_cnt_q == LAST_ELEM) begin
            grp_done_s = 1'b1;
            acc_d      = {SUM_W{1'b0}};
            elem_cnt_d = {CNT_W{1'b0}};
          end else begin
            acc_d      = sum_s;
            elem_cnt_d = elem_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          acc_d      = acc_q;
          elem_cnt_d = elem_cnt_q;
        end
      end
      default: begin
        state_d    = IDLE;
        acc_d      = {SUM_W{1'b0}};
        elem_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // FIFO handshake decode: a full FIFO still accepts a push when it pops in the same cycle
  assign pop_s     = beam_valid_q & beam_ready;
  assign full_s    = (occ_q == FULL_OCC);
  assign push_ok_s = grp_done_s & (~full_s | pop_s);
  assign drop_s    = grp_done_s & full_s & ~pop_s;

  // FIFO pointers, occupancy, head register and status outputs
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    beam_out_d   = beam_out_q;
    overflow_d   = overflow_q;
    beam_count_d = beam_count_q;

    if (push_ok_s) begin
      wr_ptr_d     = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      beam_count_d = beam_count_q + 16'd1;
    end else begin
      wr_ptr_d     = wr_ptr_q;
      beam_count_d = beam_count_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   occ_d = occ_q + {{(OCC_W-1){1'b0}}, 1'b1};
      2'b01:   occ_d = occ_q - {{(OCC_W-1){1'b0}}, 1'b1};
      default: occ_d = occ_q;
    endcase

    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    // The new head is the word being pushed when nothing else remains queued,
    // otherwise it already sits in memory; an empty FIFO keeps the last value.
    if (occ_d == {OCC_W{1'b0}}) begin
      beam_out_d = beam_out_q;
    end else if (push_ok_s &&
                 ((occ_q == {OCC_W{1'b0}}) ||
                  ((occ_q == {{(OCC_W-1){1'b0}}, 1'b1}) && pop_s))) begin
      beam_out_d = sum_s;
    end else begin
      beam_out_d = fifo_mem_q[rd_ptr_d];
    end

    beam_valid_d = (occ_d != {OCC_W{1'b0}});
    busy_d       = (state_d == ACCUM);
  end

  // State, accumulator, FIFO control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= {SUM_W{1'b0}};
      elem_cnt_q   <= {CNT_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      occ_q        <= {OCC_W{1'b0}};
      beam_out_q   <= {SUM_W{1'b0}};
      beam_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      beam_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      elem_cnt_q   <= elem_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      beam_out_q   <= beam_out_d;
      beam_valid_q <= beam_valid_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      beam_count_q <= beam_count_d;
    end
  end

  // FIFO storage write; contents are not cleared since occupancy governs validity
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) begin
      fifo_mem_q[wr_ptr_q] <= sum_s;
    end
  end

  assign beam_out   = beam_out_q;
  assign beam_valid = beam_valid_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign beam_count = beam_count_q;

endmodule

// File: doc/beam_sum_accumulator.md
Name: beam_sum_accumulator

Overview:
- Downstream stage of the delay beamformer.
- Consumes the stream of selected samples (sample value plus data-good strobe) and sums every NUM_ELEM good samples into one beam sample.
- Queues finished beam samples in a first-word-fall-through FIFO with a valid/ready handshake toward readout logic.
- Sits between the delay beamformer and the capture/readout interface.

Parameters:
- DATA_W, 12, width of incoming sample (unsigned ADC code).
- NUM_ELEM, 8, good samples summed per beam sample; power of two, 2..64.
- FIFO_DEPTH, 16, beam-sample FIFO entries; power of two, >=2.
- SUM_W (localparam), DATA_W+log2(NUM_ELEM) = 15, beam sample width; cannot overflow.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  acquisition enable, same signal that drives the beamformer
- sample_in  in  DATA_W  selected sample value from beamformer
- sample_good  in  1  qualifies sample_in for one cycle
- beam_out  out  SUM_W  FIFO head beam sample
- beam_valid  out  1  FIFO not empty
- beam_ready  in  1  consumer accepts beam_out this cycle
- busy  out  1  state is ACCUM
- overflow  out  1  sticky: a completed beam sample was dropped (FIFO full)
- beam_count  out  16  number of beam samples pushed into FIFO

Behaviour:
- Reset (rst=1 at a clock edge):
  - State IDLE; accumulator, element counter, FIFO pointers/occupancy, beam_count, overflow all 0.
  - beam_valid=0, busy=0, beam_out=0. FIFO contents discarded.
  - Reset wins over every other event in the same cycle, including mid-group and mid-handshake.
- States:
  - IDLE: sample_good ignored. start=1 -> ACCUM next cycle; accumulator and element counter cleared.
  - ACCUM: busy=1. start=0 -> IDLE next cycle; the partial group is discarded (acc and counter cleared), and a sample_good in that same cycle is ignored. FIFO contents are kept across IDLE.
- Accumulation (ACCUM, start=1, sample_good=1):
  - elem_cnt < NUM_ELEM-1: acc <= acc + sample_in; elem_cnt <= elem_cnt+1.
  - elem_cnt == NUM_ELEM-1 (group complete):
    - push value = acc + sample_in (full SUM_W width, zero-extended).
    - acc <= 0, elem_cnt <= 0 in the same cycle, so back-to-back good samples start the next group with no gap.
- sample_good=0: acc and elem_cnt hold.
- Push latency: group-completing sample at edge t -> beam_valid=1 and beam_out=sum visible after edge t (registered; one cycle).
- FIFO, first-word-fall-through:
  - beam_out always shows the head entry when beam_valid=1; beam_out holds its last value when empty.
  - Pop when beam_valid & beam_ready at an edge.
  - beam_ready while empty is ignored.
- Full FIFO:
  - Push attempted with no pop in the same cycle: sample dropped, overflow <= 1 (sticky until rst), beam_count not incremented, FIFO unchanged.
  - Push and pop in the same cycle: both succeed, occupancy unchanged, no overflow.
- Empty FIFO: push and pop cannot coincide (beam_valid=0). The pushed word appears next cycle.
- beam_count: increments on each accepted push; wraps 65535 -> 0.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked explicitly, from 0 to FIFO_DEPTH.
- start toggles: re-entering ACCUM always begins a fresh group with acc=0.
- Unknown or X on sample_good while start=0 must not corrupt state.

Test Plan:
- Basic sum:
  - Stimulus: rst, then start=1; 8 consecutive good samples 100,200,...,800, beam_ready=0.
  - Response: one cycle after the 8th sample, beam_valid=1, beam_out=3600, beam_count=1, busy=1.
- Max value and gaps:
  - Stimulus: 8 good samples of 4095, with sample_good=0 gaps of 1-3 cycles between them.
  - Response: beam_out=32760, no wrap. Gaps do not alter the sum.
- Abort mid-group:
  - Stimulus: 5 good samples of 1000, start=0 for 1 cycle, start=1, then 8 samples of 10.
  - Response: only beam_out=80 is pushed; beam_count=1; the partial 5000 never appears.
- FIFO full and overflow:
  - Stimulus: beam_ready=0, 17 groups of value 1 each (sum 8).
  - Response: 16 entries held, overflow=1 after the 17th group, beam_count=16.
  - Then hold beam_ready=1: 16 pops of 8, then beam_valid=0.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full (16), beam_ready=1 in the same cycle a group completes with sum 40.
  - Response: occupancy stays 16, overflow stays 0, 40 is the last word popped, beam_count=17.
- Reset mid-operation:
  - Stimulus: assert rst with 3 entries queued and a partial group in progress.
  - Response: the next cycle shows beam_valid=0, overflow=0, beam_count=0, busy=0. After reset, a new group sums from 0.
